// File: rtl/regfile_scb_if.sv
// Register-file/scoreboard bus: read ports, reservation port, writeback port, flush.
// Latency: none (wires only); read data and ready flags are combinational at the slave.
// Backpressure: alloc_ready gates reservations; writeback and flush are never stalled.
interface regfile_scb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            rd1_rdy;
  logic            rd2_rdy;
  logic            alloc_valid;
  logic [AW-1:0]   alloc_rd;
  logic            alloc_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic [AW:0]     busy_cnt;

  // Pipeline side: issues reads, reservations, writebacks and flushes.
  modport master (
    output rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data, flush,
    input  rd1, rd2, rd1_rdy, rd2_rdy, alloc_ready, busy_cnt
  );

  // Register file side.
  modport slave (
    input  rs1, rs2, alloc_valid, alloc_rd, wb_valid, wb_rd, wb_data, flush,
    output rd1, rd2, rd1_rdy, rd2_rdy, alloc_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_scb.sv
// Register file with per-register busy scoreboard; optional same-cycle wb bypass (REGFILE_SCB_BYPASS_EN).
// Latency: reads combinational from state; writeback visible next cycle (same cycle with bypass).
// Backpressure: alloc_ready drops while the target register is already pending.
module regfile_scb #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_scb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;

  logic alloc_zero;
  logic wb_zero;
  logic alloc_acc;
  logic alloc_set;
  logic wb_wr;
  logic wb_clr;

  // Reservation/writeback qualification; reg 0 is inert when hardwired to zero.
  always_comb begin
    alloc_zero      = (ZERO_REG != 0) && (bus.alloc_rd == '0);
    wb_zero         = (ZERO_REG != 0) && (bus.wb_rd == '0);
    bus.alloc_ready = !busy_q[bus.alloc_rd] || alloc_zero;
    alloc_acc       = bus.alloc_valid && bus.alloc_ready && !bus.flush;
    alloc_set       = alloc_acc && !alloc_zero;
    wb_wr           = bus.wb_valid && !wb_zero;
    // An accepted alloc implies its target was idle, so a same-register
    // writeback never finds a set bit and the count nets to +1.
    wb_clr          = wb_wr && busy_q[bus.wb_rd];
  end

  // Next-state for data, busy bits and pending count; alloc beats wb, flush beats both.
  always_comb begin
    regs_d     = regs_q;
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (wb_wr) begin
      regs_d[bus.wb_rd] = bus.wb_data;
      busy_d[bus.wb_rd] = 1'b0;
    end
    if (alloc_set) begin
      busy_d[bus.alloc_rd] = 1'b1;
    end
    busy_cnt_d = busy_cnt_q + {{AW{1'b0}}, alloc_set} - {{AW{1'b0}}, wb_clr};
    if (bus.flush) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end
  end

  // State registers; reset clears data, busy bits and count asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Read ports: registered state, optionally overridden by an in-flight writeback.
  always_comb begin
    bus.rd1      = regs_q[bus.rs1];
    bus.rd2      = regs_q[bus.rs2];
    bus.rd1_rdy  = !busy_q[bus.rs1];
    bus.rd2_rdy  = !busy_q[bus.rs2];
    bus.busy_cnt = busy_cnt_q;
`ifdef REGFILE_SCB_BYPASS_EN
    // Forwarding is suppressed during reset so reset outputs stay clean.
    if (reset_n && wb_wr && (bus.wb_rd == bus.rs1)) begin
      bus.rd1     = bus.wb_data;
      bus.rd1_rdy = 1'b1;
    end
    if (reset_n && wb_wr && (bus.wb_rd == bus.rs2)) begin
      bus.rd2     = bus.wb_data;
      bus.rd2_rdy = 1'b1;
    end
`endif
  end
endmodule
